uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the DS1302/PC-link path. It adds configurable data width, parity mode and stop-bit count. Each bit is sampled by 3-point majority vote, and false starts (glitches) are rejected. Every received character is reported with parity-error, framing-error and break flags. It sits between the board RX pin and command-parsing logic and produces one valid pulse per character.

Parameters:
CLK_FREQ, 24000000, system clock frequency in Hz
UART_BPS, 115200, baud rate
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; 1 or 2
Derived localparams:
- PERIOD = CLK_FREQ/UART_BPS (integer division).
- HALF = PERIOD/2.
- Elaboration must fail if PERIOD < 8.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  asynchronous serial input; idle high
rx_valid  out  1  single-cycle pulse when a character completes
rx_data  out  DATA_BITS  received character, LSB first on the wire
parity_err  out  1  parity mismatch on the last character; 0 when PARITY=0
frame_err  out  1  a stop bit sampled low on the last character
break_det  out  1  single-cycle pulse: data, parity and stop bits all sampled 0
rx_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - rx_valid, rx_data, parity_err, frame_err, break_det and rx_busy all 0.
  - Both synchroniser flops reset to 1 (idle), so reset release never produces a spurious edge.
  - FSM goes to IDLE; baud counter and bit index go to 0.
- Synchroniser: 2-flop, plus a third registered copy used for falling-edge detect. The synchronised line is what gets sampled.
- Baud counter: 0..PERIOD-1; wraps to 0 at PERIOD-1 while not in IDLE; held at 0 in IDLE.
- Majority sampling:
  - Sample points are counter values HALF-1, HALF and HALF+1.
  - The bit value is the majority of the three, registered at HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised 1->0 edge moves to START with the counter cleared.
  - START: at HALF+1, a majority of 1 returns to IDLE (glitch rejected, no outputs change). Otherwise go to DATA at PERIOD-1.
  - DATA: shift in bit_idx 0..DATA_BITS-1, LSB first. At PERIOD-1 of the last bit, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: store the sampled bit. Expected bit is ^data for even mode and ~^data for odd mode. Go to STOP at PERIOD-1.
  - STOP: sample each stop bit at HALF+1. The frame completes at HALF+1 of the final stop bit; the FSM then returns to IDLE immediately, half a bit early, so back-to-back frames are accepted.
  - With STOP_BITS=2, a low first stop bit still sets frame_err, and reception continues through the second stop bit.
- Completion cycle (edge after the final stop sample):
  - rx_valid=1 for exactly one cycle.
  - rx_data, parity_err and frame_err update on that same edge and hold until the next completion.
  - break_det pulses with rx_valid when the break condition holds.
- A frame with errors is still delivered (rx_valid=1 plus flags); errors never suppress delivery.
- After a frame_err, IDLE waits for the line to return high before a new start can be detected. The edge detector gives this naturally; no extra state is required.
- rx_busy: combinational decode of state != IDLE.
- Reset asserted mid-frame aborts the frame immediately; no rx_valid is emitted.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (3-bit encoding);
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - a function computing expected parity from data and mode.
- One natural sub-module: uart_baud_sampler. It contains the synchroniser, the falling-edge detect, the baud counter and the majority-vote sampler, and outputs sample_strobe, bit_val, bit_end and start_edge.
- The FSM, shift register and output registers live in the top module.

Test Plan:
Default parameters (PERIOD=208, 8N1): send 0xA5 -> exactly one rx_valid pulse; rx_data=0xA5; parity_err=0; frame_err=0; rx_busy falls on the pulse cycle.
DATA_BITS=7, PARITY=2: send 0x41 with correct parity 0, then 0x41 with parity 1 -> parity_err 0 then 1; rx_data=0x41 both times.
Default parameters: 40-cycle low glitch on an idle line -> no rx_valid; rx_busy returns to 0 before cycle 110.
STOP_BITS=2: 0x3C sent with the second stop bit low -> rx_valid fires; frame_err=1; next correct frame 0x3C clears frame_err.
Default parameters: line held low for 3 frame times, then released -> one rx_valid with rx_data=0x00, frame_err=1 and break_det=1; no further rx_valid until a new start edge.
Default parameters: single one-cycle spike inside bit 3 of 0xFF, plus rst_n asserted mid-frame on a second frame -> first frame gives rx_data=0xFF (majority vote rejects the spike); the aborted frame gives no rx_valid, and all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver:
// FSM state encoding, parity modes and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Zero padding above the data width leaves the XOR unchanged.
  function automatic logic exp_parity(
    input logic [8:0] d,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_sampler.sv
// Line synchroniser, start-edge detect, baud counter
// and 3-point majority sampler for the UART receiver.
module uart_baud_sampler #(
  parameter int PERIOD = 208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  input  logic run,
  output logic start_edge,
  output logic sample_strobe,
  output logic bit_val,
  output logic bit_end
);

  localparam int HALF = PERIOD / 2;
  localparam int CW   = $clog2(PERIOD);

  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic          v0, v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_edge = s3 & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == CW'(PERIOD - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cnt == CW'(HALF - 1)) v0 <= s2;
      if (cnt == CW'(HALF))     v1 <= s2;
    end
  end

  // Third vote is the live synchronised line at HALF+1.
  assign bit_val = (v0 & v1) | (v0 & s2) | (v1 & s2);

  assign sample_strobe = run && (cnt == CW'(HALF + 1));
  assign bit_end       = run && (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: width, parity, stop bits,
// glitch rejection and parity/framing/break reporting.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 24000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_busy
);

  import uart_pkg::*;

  localparam int PERIOD = CLK_FREQ / UART_BPS;

  if (PERIOD < 8) begin : g_bad_period
    $error("uart_rx_cfg: PERIOD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end

  rx_state_t            state;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 zero_acc;
  logic                 stop_idx;
  logic                 par_bad;

  logic start_edge, sample_strobe, bit_val, bit_end;

  assign rx_busy = (state != S_IDLE);

  uart_baud_sampler #(
    .PERIOD(PERIOD)
  ) u_samp (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .run          (rx_busy),
    .start_edge   (start_edge),
    .sample_strobe(sample_strobe),
    .bit_val      (bit_val),
    .bit_end      (bit_end)
  );

  assign par_bad = (PARITY != PAR_NONE) &&
    (par_bit != exp_parity(9'(shreg), PARITY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      zero_acc   <= 1'b0;
      stop_idx   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      break_det <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_edge) begin
            state    <= S_START;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            zero_acc <= 1'b1;
          end
        end
        S_START: begin
          if (sample_strobe && bit_val) state <= S_IDLE;
          else if (bit_end)             state <= S_DATA;
        end
        S_DATA: begin
          if (sample_strobe) begin
            shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
            zero_acc <= zero_acc & ~bit_val;
          end
          if (bit_end) begin
            if (bit_idx == 4'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end
        end
        S_PARITY: begin
          if (sample_strobe) begin
            par_bit  <= bit_val;
            zero_acc <= zero_acc & ~bit_val;
          end
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          // Finish mid-bit so the next start edge is not missed.
          if (sample_strobe) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state      <= S_IDLE;
              rx_valid   <= 1'b1;
              rx_data    <= shreg;
              parity_err <= par_bad;
              frame_err  <= ferr_acc | ~bit_val;
              break_det  <= zero_acc & ~bit_val;
            end else begin
              stop_idx <= 1'b1;
              ferr_acc <= ~bit_val;
              zero_acc <= zero_acc & ~bit_val;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations
// (8N1, 7E1, 8N2) driven with directed frames.
module tb_uart_rx_cfg;

  localparam int P = 208;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic l0 = 1'b1, l1 = 1'b1, l2 = 1'b1;

  logic       v0, pe0, fe0, bk0, by0;
  logic [7:0] d0;
  logic       v1, pe1, fe1, bk1, by1;
  logic [6:0] d1;
  logic       v2, pe2, fe2, bk2, by2;
  logic [7:0] d2;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(l0),
    .rx_valid(v0), .rx_data(d0), .parity_err(pe0),
    .frame_err(fe0), .break_det(bk0), .rx_busy(by0)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(l1),
    .rx_valid(v1), .rx_data(d1), .parity_err(pe1),
    .frame_err(fe1), .break_det(bk1), .rx_busy(by1)
  );

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(l2),
    .rx_valid(v2), .rx_data(d2), .parity_err(pe2),
    .frame_err(fe2), .break_det(bk2), .rx_busy(by2)
  );

  typedef struct {
    int d;
    int pe;
    int fe;
    int bk;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic expect_rx(int w, int d, int pe, int fe, int bk);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk;
    case (w)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_line(int w, logic v);
    case (w)
      0: l0 = v;
      1: l1 = v;
      default: l2 = v;
    endcase
  endtask

  task automatic send(int w, logic [15:0] bits, int n, int spike = -1);
    for (int i = 0; i < n; i++) begin
      set_line(w, bits[i]);
      for (int c = 0; c < P; c++) begin
        if (i == spike && c == 105) set_line(w, ~bits[i]);
        if (i == spike && c == 106) set_line(w, bits[i]);
        @(posedge clk);
      end
    end
    set_line(w, 1'b1);
  endtask

  task automatic idle(int nb);
    repeat (nb * P) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (v0) begin
      chk("u0_expected", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("u0_data", d0, e0.d);
        chk("u0_perr", pe0, e0.pe);
        chk("u0_ferr", fe0, e0.fe);
        chk("u0_break", bk0, e0.bk);
        chk("u0_busy_at_valid", by0, 0);
      end
    end else if (bk0) begin
      chk("u0_break_without_valid", bk0, 0);
    end
  end

  always @(negedge clk) begin
    if (v1) begin
      chk("u1_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("u1_data", d1, e1.d);
        chk("u1_perr", pe1, e1.pe);
        chk("u1_ferr", fe1, e1.fe);
        chk("u1_break", bk1, e1.bk);
      end
    end
  end

  always @(negedge clk) begin
    if (v2) begin
      chk("u2_expected", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("u2_data", d2, e2.d);
        chk("u2_perr", pe2, e2.pe);
        chk("u2_ferr", fe2, e2.fe);
        chk("u2_break", bk2, e2.bk);
      end
    end
  end

  initial begin
    int  last;
    bit  seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_perr", pe0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_break", bk0, 0);
    chk("rst_busy", by0, 0);
    rst_n = 1'b1;
    idle(1);

    // 8N1 0xA5
    expect_rx(0, 'hA5, 0, 0, 0);
    send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    idle(2);

    // 7E1 0x41: good parity, then bad parity
    expect_rx(1, 'h41, 0, 0, 0);
    send(1, {6'h3f, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    idle(2);
    expect_rx(1, 'h41, 1, 0, 0);
    send(1, {6'h3f, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    idle(2);

    // 40-cycle glitch on idle line
    seen = 1'b0;
    last = -1;
    l0 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (c == 40) l0 = 1'b1;
      @(posedge clk);
      #1;
      if (by0) begin
        seen = 1'b1;
        last = c;
      end
    end
    chk("glitch_busy_seen", int'(seen), 1);
    chk("glitch_clear_lt110", int'(last < 110), 1);
    idle(1);

    // 8N2: second stop low, then a clean frame
    expect_rx(2, 'h3C, 0, 1, 0);
    send(2, {5'h1f, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    idle(2);
    expect_rx(2, 'h3C, 0, 0, 0);
    send(2, {5'h1f, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(2);

    // break: low for three frame times
    expect_rx(0, 'h00, 0, 1, 1);
    l0 = 1'b0;
    repeat (30 * P) @(posedge clk);
    l0 = 1'b1;
    idle(3);

    // 0xFF with a one-cycle spike in data bit 3
    expect_rx(0, 'hFF, 0, 0, 0);
    send(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10, 4);
    idle(2);

    // reset mid-frame aborts reception
    send(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", v0, 0);
    chk("abort_data", d0, 0);
    chk("abort_perr", pe0, 0);
    chk("abort_ferr", fe0, 0);
    chk("abort_break", bk0, 0);
    chk("abort_busy", by0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    expect_rx(0, 'h5A, 0, 0, 0);
    send(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
    idle(2);

    chk("u0_drained", q0.size(), 0);
    chk("u1_drained", q1.size(), 0);
    chk("u2_drained", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
